unidade_busca: RTL and testbench



---
 rtl/pkg_processador.sv | 19 +
 rtl/contador_programa.sv | 36 +++
 rtl/unidade_busca.sv | 121 ++++++++++++
 tb/tb_unidade_busca.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_processador.sv
// Shared processor definitions: opcodes, instruction field positions and fetch FSM states.
package pkg_processador;

  localparam int OPCODE_MSB     = 31;
  localparam int OPCODE_LSB     = 27;
  localparam int JUMP_ALVO_BITS = 27;

  localparam logic [4:0] OP_BRANCH = 5'd12;
  localparam logic [4:0] OP_JUMP   = 5'd16;
  localparam logic [4:0] OP_HALT   = 5'd18;
  localparam logic [4:0] OP_JR     = 5'd27;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_BUSCA  = 2'd1,
    ST_PARADO = 2'd2
  } estado_t;

endpackage

// File: rtl/contador_programa.sv
// Program counter: load has priority over increment; holds when neither is requested.
// Updates on the clock edge; synchronous active-low reset to ENDERECO_INICIAL.
module contador_programa #(
  parameter int unsigned ENDERECO_INICIAL = 1,
  parameter int          LARGURA          = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carregar,
  input  logic               incrementar,
  input  logic [LARGURA-1:0] valor_carga,
  output logic [LARGURA-1:0] pc
);

  logic [LARGURA-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (carregar) begin
      pc_d = valor_carga;
    end else if (incrementar) begin
      pc_d = pc_q + LARGURA'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q <= LARGURA'(ENDERECO_INICIAL);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/unidade_busca.sv
// Fetch stage: PC, instruction register, local JUMP/HALT resolution; 1-cycle fetch latency.
// stall freezes PC, IR and state; a downstream redirect overrides stall and flushes one slot.
module unidade_busca
  import pkg_processador::*;
#(
  parameter int unsigned ENDERECO_INICIAL = 1,
  parameter int          LARGURA          = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               desvio,
  input  logic [LARGURA-1:0] alvo_desvio,
  input  logic [LARGURA-1:0] instrucao,
  output logic [LARGURA-1:0] endereco,
  output logic [LARGURA-1:0] instrucao_saida,
  output logic [LARGURA-1:0] pc_saida,
  output logic               valido,
  output logic               parado
);

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] ir_q, ir_d;
  logic [LARGURA-1:0] pc_saida_q, pc_saida_d;
  logic               valido_q, valido_d;
  logic               parado_q, parado_d;

  logic               pc_carregar, pc_incrementar;
  logic [LARGURA-1:0] pc_carga, pc_atual;
  logic [4:0]         opcode;

  assign opcode = instrucao[OPCODE_MSB:OPCODE_LSB];

  contador_programa #(
    .ENDERECO_INICIAL(ENDERECO_INICIAL),
    .LARGURA         (LARGURA)
  ) u_pc (
    .clock      (clock),
    .reset      (reset),
    .carregar   (pc_carregar),
    .incrementar(pc_incrementar),
    .valor_carga(pc_carga),
    .pc         (pc_atual)
  );

  always_comb begin
    estado_d       = estado_q;
    ir_d           = ir_q;
    pc_saida_d     = pc_saida_q;
    valido_d       = valido_q;
    parado_d       = parado_q;
    pc_carregar    = 1'b0;
    pc_incrementar = 1'b0;
    pc_carga       = alvo_desvio;

    case (estado_q)
      ST_INIT: begin
        // Memory read is still settling on the first edge; nothing to capture.
        valido_d = 1'b0;
        estado_d = ST_BUSCA;
      end
      ST_BUSCA: begin
        if (desvio) begin
          pc_carregar = 1'b1;
          valido_d    = 1'b0;
        end else if (!stall) begin
          if (opcode == OP_JUMP) begin
            pc_carregar = 1'b1;
            pc_carga    = {{(LARGURA-JUMP_ALVO_BITS){1'b0}}, instrucao[JUMP_ALVO_BITS-1:0]};
            valido_d    = 1'b0;
          end else begin
            ir_d       = instrucao;
            pc_saida_d = pc_atual;
            valido_d   = 1'b1;
            if (opcode == OP_HALT) begin
              estado_d = ST_PARADO;
            end else begin
              pc_incrementar = 1'b1;
            end
          end
        end
      end
      ST_PARADO: begin
        valido_d = 1'b0;
        parado_d = 1'b1;
        // An older branch still in flight may pull us out of the halt.
        if (desvio) begin
          pc_carregar = 1'b1;
          parado_d    = 1'b0;
          estado_d    = ST_BUSCA;
        end
      end
      default: begin
        estado_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q   <= ST_INIT;
      ir_q       <= '0;
      pc_saida_q <= '0;
      valido_q   <= 1'b0;
      parado_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      ir_q       <= ir_d;
      pc_saida_q <= pc_saida_d;
      valido_q   <= valido_d;
      parado_q   <= parado_d;
    end
  end

  assign endereco        = pc_atual;
  assign instrucao_saida = ir_q;
  assign pc_saida        = pc_saida_q;
  assign valido          = valido_q;
  assign parado          = parado_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural fetch model over a 256-word memory.
module tb_unidade_busca;

  logic        clock;
  logic        reset, stall, desvio;
  logic [31:0] alvo_desvio, instrucao, endereco, instrucao_saida, pc_saida;
  logic        valido, parado;

  logic [31:0] mem [0:255];
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic        rst, stl, dsv;
    logic [31:0] alvo, e_end, e_pcs;
    logic        e_vld, e_par;
  } vetor_t;

  vetor_t tab[$];

  logic [31:0] m_pc, m_ir, m_pcs;
  logic        m_vld, m_par;
  int          m_fase;

  unidade_busca #(.ENDERECO_INICIAL(1), .LARGURA(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .desvio         (desvio),
    .alvo_desvio    (alvo_desvio),
    .instrucao      (instrucao),
    .endereco       (endereco),
    .instrucao_saida(instrucao_saida),
    .pc_saida       (pc_saida),
    .valido         (valido),
    .parado         (parado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign instrucao = mem[endereco[7:0]];

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic aplica(input logic rst, input logic stl, input logic dsv, input logic [31:0] alvo);
    reset       = rst;
    stall       = stl;
    desvio      = dsv;
    alvo_desvio = alvo;
  endtask

  task automatic confere(input string tag, input logic [31:0] e_end, input logic [31:0] e_pcs,
                         input logic e_vld, input logic e_par);
    check({tag, " endereco"}, endereco, e_end);
    check({tag, " pc_saida"}, pc_saida, e_pcs);
    check({tag, " valido"}, 32'(valido), 32'(e_vld));
    check({tag, " parado"}, 32'(parado), 32'(e_par));
    if (e_vld) check({tag, " instrucao_saida"}, instrucao_saida, mem[e_pcs[7:0]]);
  endtask

  function automatic vetor_t vt(input logic rst, input logic stl, input logic dsv, input logic [31:0] alvo,
                                input logic [31:0] e_end, input logic [31:0] e_pcs,
                                input logic e_vld, input logic e_par);
    vetor_t v;
    v.rst = rst; v.stl = stl; v.dsv = dsv; v.alvo = alvo;
    v.e_end = e_end; v.e_pcs = e_pcs; v.e_vld = e_vld; v.e_par = e_par;
    return v;
  endfunction

  // Fetch behaviour expressed directly from the stage's rules, one clock edge at a time.
  task automatic modelo_passo();
    logic [31:0] w;
    w = mem[m_pc[7:0]];
    if (!reset) begin
      m_pc = 32'd1; m_ir = '0; m_pcs = '0; m_vld = 1'b0; m_par = 1'b0; m_fase = 0;
    end else if (m_fase == 0) begin
      m_fase = 1;
    end else if (m_fase == 1) begin
      if (desvio) begin
        m_pc  = alvo_desvio;
        m_vld = 1'b0;
      end else if (!stall) begin
        if (w[31:27] == 5'd16) begin
          m_pc  = w & 32'h07FF_FFFF;
          m_vld = 1'b0;
        end else begin
          m_ir  = w;
          m_pcs = m_pc;
          m_vld = 1'b1;
          if (w[31:27] == 5'd18) m_fase = 2;
          else m_pc = m_pc + 32'd1;
        end
      end
    end else begin
      m_vld = 1'b0;
      m_par = 1'b1;
      if (desvio) begin
        m_pc   = alvo_desvio;
        m_par  = 1'b0;
        m_fase = 1;
      end
    end
  endtask

  initial begin
    aplica(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 256; i++) mem[i] = {5'd1, 27'(i * 3 + 7)};
    mem[5]   = {5'd16, 27'd86};
    mem[124] = {5'd18, 27'h5};

    tab.push_back(vt(0, 0, 0, 0,   1,   0, 0, 0));
    tab.push_back(vt(1, 0, 0, 0,   1,   0, 0, 0));
    tab.push_back(vt(1, 0, 0, 0,   2,   1, 1, 0));
    tab.push_back(vt(1, 0, 0, 0,   3,   2, 1, 0));
    tab.push_back(vt(1, 0, 0, 0,   4,   3, 1, 0));
    tab.push_back(vt(1, 0, 0, 0,   5,   4, 1, 0));
    tab.push_back(vt(1, 0, 0, 0,  86,   4, 0, 0));
    tab.push_back(vt(1, 0, 0, 0,  87,  86, 1, 0));
    tab.push_back(vt(1, 1, 0, 0,  87,  86, 1, 0));
    tab.push_back(vt(1, 1, 0, 0,  87,  86, 1, 0));
    tab.push_back(vt(1, 1, 0, 0,  87,  86, 1, 0));
    tab.push_back(vt(1, 0, 0, 0,  88,  87, 1, 0));
    tab.push_back(vt(1, 1, 1, 84, 84,  87, 0, 0));
    tab.push_back(vt(1, 0, 0, 0,  85,  84, 1, 0));
    tab.push_back(vt(1, 0, 1, 120, 120, 84, 0, 0));
    tab.push_back(vt(1, 0, 0, 0, 121, 120, 1, 0));
    tab.push_back(vt(1, 0, 0, 0, 122, 121, 1, 0));
    tab.push_back(vt(1, 0, 0, 0, 123, 122, 1, 0));
    tab.push_back(vt(1, 0, 0, 0, 124, 123, 1, 0));
    tab.push_back(vt(1, 0, 0, 0, 124, 124, 1, 0));
    tab.push_back(vt(1, 0, 0, 0, 124, 124, 0, 1));

    foreach (tab[i]) begin
      aplica(tab[i].rst, tab[i].stl, tab[i].dsv, tab[i].alvo);
      tick();
      confere($sformatf("vetor %0d", i), tab[i].e_end, tab[i].e_pcs, tab[i].e_vld, tab[i].e_par);
      if (!tab[i].rst) check($sformatf("vetor %0d ir_reset", i), instrucao_saida, 32'd0);
    end

    aplica(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      confere("halt_hold", 124, 124, 0, 1);
    end

    aplica(0, 0, 0, 0); tick(); confere("rst_parado", 1, 0, 0, 0);
    check("rst_parado ir", instrucao_saida, 32'd0);
    aplica(1, 0, 0, 0); tick(); confere("rst_parado init", 1, 0, 0, 0);
    tick(); confere("rst_parado f1", 2, 1, 1, 0);
    tick(); confere("rst_parado f2", 3, 2, 1, 0);

    aplica(1, 1, 0, 0); tick(); confere("stall_pre_rst", 3, 2, 1, 0);
    aplica(0, 1, 0, 0); tick(); confere("rst_stall", 1, 0, 0, 0);
    check("rst_stall ir", instrucao_saida, 32'd0);
    aplica(1, 0, 0, 0); tick(); confere("rst_stall init", 1, 0, 0, 0);
    tick(); confere("rst_stall f1", 2, 1, 1, 0);

    aplica(1, 0, 1, 5); tick(); confere("jump_dir", 5, 1, 0, 0);
    aplica(1, 1, 0, 0); tick(); confere("jump_stall a", 5, 1, 0, 0);
    tick(); confere("jump_stall b", 5, 1, 0, 0);
    aplica(1, 0, 0, 0); tick(); confere("jump_exec", 86, 1, 0, 0);
    tick(); confere("jump_dest", 87, 86, 1, 0);

    aplica(1, 0, 1, 124); tick(); confere("to_halt", 124, 86, 0, 0);
    aplica(1, 0, 0, 0); tick(); confere("halt_word", 124, 124, 1, 0);
    tick(); confere("halt_par", 124, 124, 0, 1);
    aplica(1, 0, 1, 10); tick(); confere("halt_exit", 10, 124, 0, 0);
    aplica(1, 0, 0, 0); tick(); confere("halt_exit f", 11, 10, 1, 0);

    aplica(1, 0, 1, 32'hFFFF_FFFF); tick(); confere("wrap dir", 32'hFFFF_FFFF, 10, 0, 0);
    aplica(1, 0, 0, 0); tick(); confere("wrap a", 0, 32'hFFFF_FFFF, 1, 0);
    tick(); confere("wrap b", 1, 0, 1, 0);

    for (int i = 0; i < 256; i++) begin
      int r;
      int op;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        mem[i] = {5'd18, 27'($urandom)};
      end else if (r < 3) begin
        mem[i] = {5'd16, 27'($urandom_range(0, 255))};
      end else begin
        op = $urandom_range(0, 31);
        if (op == 16 || op == 18) op = 1;
        mem[i] = {5'(op), 27'($urandom)};
      end
    end

    for (int k = 0; k < 3000; k++) begin
      reset  = (k == 0 || $urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      stall  = ($urandom_range(0, 3) == 0);
      desvio = ($urandom_range(0, 7) == 0);
      alvo_desvio = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                 : 32'($urandom_range(0, 255));
      modelo_passo();
      tick();
      check($sformatf("rnd %0d endereco", k), endereco, m_pc);
      check($sformatf("rnd %0d instrucao_saida", k), instrucao_saida, m_ir);
      check($sformatf("rnd %0d pc_saida", k), pc_saida, m_pcs);
      check($sformatf("rnd %0d valido", k), 32'(valido), 32'(m_vld));
      check($sformatf("rnd %0d parado", k), 32'(parado), 32'(m_par));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
